// File: rtl/param_int_packer_pkg.sv
// Shared helpers and default widths for the integer lane packer.
package param_int_pkg;

  // Smallest r with 2**r >= v; elaboration-time only.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int unsigned DEFAULT_NUM_INPUTS = 9;
  localparam int unsigned LANE_IDX_W = clog2(DEFAULT_NUM_INPUTS);
  localparam int unsigned LANE_CNT_W = clog2(DEFAULT_NUM_INPUTS + 1);

endpackage

// File: rtl/param_int_packer_if.sv
// Word-in / packed-group-out handshake bundle for the lane packer.
interface param_int_packer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 9
);
  import param_int_pkg::*;

  localparam int unsigned CNT_W = clog2(NUM_INPUTS + 1);

  logic                               s_valid;
  logic                               s_ready;
  logic signed [DATA_WIDTH-1:0]       s_data;
  logic                               s_last;
  logic                               s_flush;
  logic                               m_valid;
  logic                               m_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]   m_data;
  logic [CNT_W-1:0]                   m_lanes;

  // Producer/consumer side of the packer.
  modport master (
    output s_valid, s_data, s_last, s_flush, m_ready,
    input  s_ready, m_valid, m_data, m_lanes
  );

  // The packer itself.
  modport slave (
    input  s_valid, s_data, s_last, s_flush, m_ready,
    output s_ready, m_valid, m_data, m_lanes
  );

endinterface

// File: rtl/param_int_packer.sv
// Double-buffered packer: serial signed words fill lanes 0.. of a group, full or
// s_last-terminated groups move to an output register presented with valid/ready.
module param_int_packer
  import param_int_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 9
) (
  input logic              clk,
  input logic              rst,
  param_int_packer_if.slave bus
);

  localparam int unsigned IDX_W = clog2(NUM_INPUTS);
  localparam int unsigned CNT_W = clog2(NUM_INPUTS + 1);
  localparam int unsigned BUS_W = NUM_INPUTS * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] fill_q, fill_d;
  logic [BUS_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] lanes_q, lanes_d;
  logic             valid_q, valid_d;

  logic cnt_last;
  logic out_free;
  logic ready;
  logic accept;
  logic complete;

  assign cnt_last = (cnt_q == LAST_IDX);
  assign out_free = !valid_q || bus.m_ready;
  // A completing word (count-full or s_last) may only enter when the output slot frees.
  assign ready    = !bus.s_flush && ((!cnt_last && !bus.s_last) || out_free);
  assign accept   = bus.s_valid && ready;
  assign complete = accept && (cnt_last || bus.s_last);

  assign bus.s_ready = ready;
  assign bus.m_valid = valid_q;
  assign bus.m_data  = out_q;
  assign bus.m_lanes = lanes_q;

  always_comb begin
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    lanes_d = lanes_q;
    valid_d = valid_q && !bus.m_ready;
    if (bus.s_flush) begin
      cnt_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      if (complete) begin
        out_d = fill_q;
        out_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
        lanes_d = CNT_W'(cnt_q) + CNT_W'(1);
        valid_d = 1'b1;
        cnt_d   = '0;
        fill_d  = '0;
      end else begin
        fill_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_param_int_packer.sv
// Directed bench for param_int_packer: group table plus backpressure, flush and reset sequences.
module tb_param_int_packer;

  localparam int unsigned W = 32;
  localparam int unsigned N = 9;
  localparam int unsigned BW = N * W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  param_int_packer_if #(.DATA_WIDTH(W), .NUM_INPUTS(N)) bus ();

  param_int_packer #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned    n;
    logic           use_last;
    logic [BW-1:0]  words;
    logic [3:0]     lanes;
    int             sum;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int base);
    logic [BW-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(base + i);
    return d;
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] d, input int idx,
                                        input logic [W-1:0] v);
    logic [BW-1:0] r;
    r = d;
    r[idx*W +: W] = v;
    return r;
  endfunction

  function automatic int lane_sum(input logic [BW-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(signed'(d[i*W +: W]));
    return s;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic last);
    int waited;
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    #1;
    while (!bus.s_ready && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stuck at 0 for word %0h, required 1", d);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_range(input int base, input int n);
    for (int i = 0; i < n; i++) send(W'(base + i), 1'b0);
  endtask

  initial begin
    logic [BW-1:0] w;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_flush = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", BW'(bus.m_valid), '0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_m_lanes", BW'(bus.m_lanes), '0);
    rst = 1'b0;
    #1;
    chk("rst_s_ready", BW'(bus.s_ready), BW'(1));
    @(posedge clk);
    #1;

    // Group table, consumer always ready
    w = '0;
    w = put(w, 0, 32'hFFFF_FFFB);
    w = put(w, 1, 32'd7);
    w = put(w, 2, 32'd2);
    tbl[0] = '{9, 1'b0, mk(1), 4'd9, 45};
    tbl[1] = '{3, 1'b1, w, 4'd3, 4};
    tbl[2] = '{1, 1'b1, put('0, 0, 32'hDEAD_BEEF), 4'd1, int'(32'hDEAD_BEEF)};
    tbl[3] = '{9, 1'b1, mk(100), 4'd9, 936};
    w = '0;
    w = put(w, 0, 32'h8000_0000);
    w = put(w, 1, 32'h7FFF_FFFF);
    w = put(w, 2, 32'hFFFF_FFFF);
    w = put(w, 3, 32'd1);
    tbl[4] = '{4, 1'b1, w, 4'd4, -1};

    bus.m_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(tbl[v].n); i++) begin
        send(tbl[v].words[i*W +: W], tbl[v].use_last && (i == int'(tbl[v].n) - 1));
      end
      chk($sformatf("tbl%0d_m_valid", v), BW'(bus.m_valid), BW'(1));
      chk($sformatf("tbl%0d_m_lanes", v), BW'(bus.m_lanes), BW'(tbl[v].lanes));
      chk($sformatf("tbl%0d_m_data", v), bus.m_data, tbl[v].words);
      chk($sformatf("tbl%0d_sum", v), BW'(lane_sum(bus.m_data)), BW'(tbl[v].sum));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_m_valid_drop", v), BW'(bus.m_valid), '0);
    end

    // s_last without s_valid does nothing
    bus.s_last = 1'b1;
    @(posedge clk);
    #1;
    bus.s_last = 1'b0;
    send_range(200, 9);
    chk("idle_last_lanes", BW'(bus.m_lanes), BW'(9));
    chk("idle_last_data", bus.m_data, mk(200));
    @(posedge clk);
    #1;

    // Backpressure: 18 words with consumer stalled
    bus.m_ready = 1'b0;
    send_range(1, 9);
    send_range(10, 8);
    chk("bp_hold_data", bus.m_data, mk(1));
    chk("bp_hold_valid", BW'(bus.m_valid), BW'(1));
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd18;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_s_ready_low%0d", k), BW'(bus.s_ready), '0);
      @(posedge clk);
      #1;
    end
    chk("bp_hold_data2", bus.m_data, mk(1));
    chk("bp_hold_lanes", BW'(bus.m_lanes), BW'(9));
    bus.m_ready = 1'b1;
    #1;
    chk("bp_s_ready_release", BW'(bus.s_ready), BW'(1));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("bp_handoff_valid", BW'(bus.m_valid), BW'(1));
    chk("bp_second_group", bus.m_data, mk(10));
    @(posedge clk);
    #1;
    chk("bp_drain_valid", BW'(bus.m_valid), '0);

    // Flush with a word presented in the same cycle
    send_range(1, 4);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd99;
    bus.s_flush = 1'b1;
    #1;
    chk("flush_s_ready", BW'(bus.s_ready), '0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_flush = 1'b0;
    chk("flush_no_output", BW'(bus.m_valid), '0);
    send_range(10, 9);
    chk("flush_group", bus.m_data, mk(10));
    chk("flush_lanes", BW'(bus.m_lanes), BW'(9));
    @(posedge clk);
    #1;

    // Flush must zero the fill register: short group after flush
    send_range(1, 4);
    bus.s_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.s_flush = 1'b0;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    chk("flush_short_data", bus.m_data, put(put('0, 0, 32'd5), 1, 32'd6));
    chk("flush_short_lanes", BW'(bus.m_lanes), BW'(2));
    @(posedge clk);
    #1;

    // Continuous stream: one word per cycle, output one cycle after each 9th accept
    for (int k = 0; k < 27; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'(k + 1);
      #1;
      chk($sformatf("stream_ready%0d", k), BW'(bus.s_ready), BW'(1));
      @(posedge clk);
      #1;
      chk($sformatf("stream_valid%0d", k), BW'(bus.m_valid), BW'(((k + 1) % 9) == 0));
      if (((k + 1) % 9) == 0) chk($sformatf("stream_data%0d", k), bus.m_data, mk(k - 7));
    end
    bus.s_valid = 1'b0;

    // Back-to-back single-word groups: m_valid stays high through hand-off
    for (int k = 0; k < 3; k++) begin
      bus.s_valid = 1'b1;
      bus.s_last  = 1'b1;
      bus.s_data  = W'(32'h1000 + k);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_valid%0d", k), BW'(bus.m_valid), BW'(1));
      chk($sformatf("b2b_lanes%0d", k), BW'(bus.m_lanes), BW'(1));
      chk($sformatf("b2b_data%0d", k), bus.m_data, put('0, 0, W'(32'h1000 + k)));
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-group with a group pending
    bus.m_ready = 1'b0;
    send_range(1, 9);
    send_range(50, 2);
    chk("pre_rst_valid", BW'(bus.m_valid), BW'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", BW'(bus.m_valid), '0);
    chk("async_rst_data", bus.m_data, '0);
    chk("async_rst_lanes", BW'(bus.m_lanes), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    send(32'hCAFE_F00D, 1'b1);
    chk("post_rst_lanes", BW'(bus.m_lanes), BW'(1));
    chk("post_rst_data", bus.m_data, put('0, 0, 32'hCAFE_F00D));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
